// File: rtl/scan_pkg.sv
// Shared definitions for the channel scan sequencer: FSM states and sizing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   scan_state_t : IDLE / DWELL / BLANK state encoding
//   CNT_W        : width of the dwell/blank counter
//   NUM_CHAN     : number of scanned channels
//   SEL_W        : width of the channel select
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  localparam int CNT_W    = 16;
  localparam int NUM_CHAN = 4;
  localparam int SEL_W    = 2;

endpackage

// File: rtl/scan_next_chan.sv
// Combinational next-channel search: finds the next set mask bit strictly above cur, modulo 4.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by the sequencer only on a channel advance.
//
// Ports:
//   mask : per-channel participation bits
//   cur  : currently selected channel
//   nxt  : next participating channel (cur itself if it is the only one set)
//   wrap : nxt <= cur, i.e. the scan restarted from a lower-or-equal channel
//   none : no channel participates; nxt is meaningless
module scan_next_chan
  import scan_pkg::*;
(
  input  logic [NUM_CHAN-1:0] mask,
  input  logic [SEL_W-1:0]    cur,
  output logic [SEL_W-1:0]    nxt,
  output logic                wrap,
  output logic                none
);

  logic [SEL_W-1:0] idx;
  logic             found;

  // Walk offsets 1..4 from cur; the 2-bit add wraps naturally modulo 4, and
  // offset 4 lands back on cur so a lone set bit selects itself.
  always_comb begin
    nxt   = cur;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CHAN; k++) begin
      idx = cur + SEL_W'(k);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  assign wrap = (nxt <= cur);
  assign none = (mask == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Channel scan sequencer: dwells DWELL_CYCLES on each masked channel, blanks BLANK_CYCLES between.
// Latency: sel_en rises the cycle after run=1 is sampled in IDLE; channel period DWELL+BLANK cycles.
// Backpressure: none; run/mask are sampled only when idle or at a channel advance.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, priority over everything
//   run    : start / keep scanning
//   mask   : per-channel participation, bit i scans channel i
//   sel    : channel select, wired straight to the 2-to-4 decoder select
//   sel_en : decoder enable, high only while dwelling
//   wrap   : one-cycle pulse on the first dwell cycle after the scan restarts low
//   busy   : high whenever not idle
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [NUM_CHAN-1:0] mask,
  output logic [SEL_W-1:0]    sel,
  output logic                sel_en,
  output logic                wrap,
  output logic                busy
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  // With no blanking the BLANK state is never entered, so this value is unused then.
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic             NO_BLANK   = (BLANK_CYCLES == 0);

  scan_state_t      state;
  logic [CNT_W-1:0] cnt;

  logic [SEL_W-1:0] search_cur;
  logic [SEL_W-1:0] next_sel;
  logic             next_wrap;
  logic             next_none;
  logic             advance;

  // Searching from the top channel yields the lowest set bit, which is the
  // start channel out of IDLE; otherwise search from the current channel.
  assign search_cur = (state == IDLE) ? SEL_W'(NUM_CHAN - 1) : sel;

  scan_next_chan u_next_chan (
    .mask (mask),
    .cur  (search_cur),
    .nxt  (next_sel),
    .wrap (next_wrap),
    .none (next_none)
  );

  // Last cycle of the channel slot: end of blank, or end of dwell when there is no blank.
  assign advance = ((state == BLANK) && (cnt == BLANK_LAST)) ||
                   ((state == DWELL) && (cnt == DWELL_LAST) && NO_BLANK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sel    <= '0;
      sel_en <= 1'b0;
      wrap   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (advance) begin
        cnt <= '0;
        if (!run || next_none) begin
          // Stop, leaving sel on the last channel scanned.
          state  <= IDLE;
          sel_en <= 1'b0;
          busy   <= 1'b0;
        end else begin
          state  <= DWELL;
          sel    <= next_sel;
          sel_en <= 1'b1;
          wrap   <= next_wrap;
          busy   <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (run && !next_none) begin
              state  <= DWELL;
              sel    <= next_sel;
              cnt    <= '0;
              sel_en <= 1'b1;
              busy   <= 1'b1;
            end
          end
          DWELL: begin
            if (cnt == DWELL_LAST) begin
              state  <= BLANK;
              cnt    <= '0;
              sel_en <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            sel_en <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1000: clock cycles each channel is held enabled (legal range 1..65535).
REQ-002 SHALL have parameter BLANK_CYCLES, default 4: clock cycles with the enable low between channels (legal range 0..65535).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port run, input, 1 bit: start/continue scanning when high.
REQ-006 SHALL have port mask, input, 4 bits: per-channel participation; bit i=1 means channel i is scanned.
REQ-007 SHALL have port sel, output, 2 bits: channel index driving the downstream 2-to-4 decoder select.
REQ-008 SHALL have port sel_en, output, 1 bit: drives the downstream decoder enable; high only during DWELL.
REQ-009 SHALL have port wrap, output, 1 bit: one-cycle pulse when the scan restarts from a lower-or-equal channel.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, DWELL and BLANK, with all outputs registered.
REQ-012 IDLE: sel_en=0 and busy=0; on an edge sampling run=1 and mask!=0 SHALL enter DWELL with sel set to the lowest set mask bit, counter cleared, and wrap=0.
REQ-013 DWELL: sel_en=1 for exactly DWELL_CYCLES cycles; on the last one SHALL go to BLANK, or directly to the channel advance if BLANK_CYCLES=0.
REQ-014 BLANK: sel_en=0 and sel unchanged for exactly BLANK_CYCLES cycles, then channel advance.
REQ-015 Channel advance: mask and run are sampled only here; if run=0 or mask=0, SHALL go to IDLE with sel unchanged.
REQ-016 Channel advance otherwise: sel SHALL become the next set mask bit strictly above sel, wrapping modulo 4 (a single set bit selects itself), and the FSM enters DWELL.
REQ-017 wrap SHALL be high for exactly the first DWELL cycle of an advance whose new sel <= previous sel; never on a start from IDLE.
REQ-018 Dropping run mid-DWELL or mid-BLANK SHALL NOT truncate the current dwell or blank; the FSM stops at the next advance.
REQ-019 Changes to mask between advances SHALL have no effect until the next advance.
REQ-020 Counter SHALL be 16 bits, cleared on every state entry, and compared against parameter minus 1; it SHALL never wrap.
REQ-021 Latency: sel_en SHALL rise on the edge that samples run=1 in IDLE, i.e. be visible in the following cycle.
REQ-022 Channel period SHALL be exactly DWELL_CYCLES+BLANK_CYCLES cycles.

Reset
REQ-023 On an edge with reset=1 SHALL force state=IDLE, counter=0, sel=0, sel_en=0, wrap=0, busy=0, regardless of state; reset SHALL have priority over run.
REQ-024 After reset deasserts, SHALL restart from IDLE per REQ-012 (no resumption of the prior channel).

Structure
REQ-025 Shared package scan_pkg SHALL hold the state enumeration (IDLE, DWELL, BLANK), the 16-bit counter width constant, and the 4-channel count constant.
REQ-026 The next-channel search SHALL be a combinational sub-module scan_next_chan (inputs: mask, current sel; outputs: next sel, wrap flag, none-set flag).
REQ-027 sel and sel_en SHALL connect directly to the decoder's select and enable with no glue logic.

Verification (DWELL_CYCLES=3, BLANK_CYCLES=1 unless stated)
REQ-028 reset, then run=1, mask=4'b1111 -> sel 0,1,2,3,0,... with sel_en pattern 1,1,1,0 per channel; wrap high for one cycle on the first cycle of sel=0 after sel=3.
REQ-029 mask=4'b1010, run=1 -> sel alternates 1,3,1; channels 0 and 2 are never enabled; wrap high on each return to 1.
REQ-030 run dropped in cycle 1 of channel 2 dwell -> 2 further dwell cycles plus 1 blank cycle, then IDLE, busy=0, sel stays 2.
REQ-031 reset pulsed mid-dwell of channel 1 -> next cycle sel=0, sel_en=0, busy=0, wrap=0.
REQ-032 run=1 with mask=0 -> stays IDLE with sel_en=0; mask changed from 4'b1111 to 4'b0001 during channel 2 dwell -> channel 2 completes, then sel=0 with a wrap pulse.
REQ-033 BLANK_CYCLES=0, mask=4'b0011 -> sel_en stays high continuously while sel toggles 0,1 every 3 cycles.
